// File: rtl/fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_pkg
// Shared front-end constants and types used by the fetch queue and by the
// rest of the pipeline.
//   fq_state_e  : fetch FSM encoding (IDLE / WAIT / DROP)
//   fq_entry_t  : one queue entry {pc_plus_4, instr}
//   NOP_INSTR   : instruction presented to decode when the queue is empty
//   DEFAULT_RESET_PC : default first fetch address after reset
// ---------------------------------------------------------------------------
package fetch_queue_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // free to issue a request
      ST_WAIT = 2'd1,   // one request outstanding, response will be kept
      ST_DROP = 2'd2    // one request outstanding, response will be thrown away
   } fq_state_e;

   typedef struct packed {
      logic [31:0] pc_plus_4;
      logic [31:0] instr;
   } fq_entry_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo_mem.sv
// ---------------------------------------------------------------------------
// fetch_fifo_mem
// DEPTH x 64-bit circular buffer holding fetched {pc_plus_4, instr} entries.
// The head entry is read combinationally so decode sees it in the same cycle
// it becomes valid.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_push     : write i_wdata at the tail (caller guarantees space)
//   i_pop      : advance the head (ignored when empty)
//   i_flush    : empty the buffer; overrides push and pop
//   i_wdata    : entry to write
//   o_rdata    : head entry (undefined contents when empty)
//   o_count    : number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo_mem
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  fq_entry_t                i_wdata,
   output fq_entry_t                o_rdata,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   fq_entry_t        r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic             w_do_pop;

   // Popping an empty buffer would corrupt the pointers, so it is masked here.
   assign w_do_pop = i_pop && (r_count != '0);

   // Storage carries no reset; validity is tracked purely by r_count.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({i_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Decoupled instruction prefetch front end. Issues sequential word fetches
// (one outstanding at a time), buffers returned words with their PC+4 and
// presents the head to decode. A redirect flushes the queue and restarts
// fetching at the target; a response still in flight at that moment is
// discarded.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   o_mem_req / o_mem_addr   : fetch request and word address
//   i_mem_ready              : memory accepts the request this cycle
//   i_mem_valid / i_mem_data : response strobe and instruction word
//   i_redirect / i_redirect_addr : taken branch/jump and its target
//   i_stall                  : decode stall, holds the head
//   o_valid / o_instruction / o_pc_plus_4 : head entry to decode
// ---------------------------------------------------------------------------
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   input  logic        i_mem_ready,
   input  logic        i_mem_valid,
   input  logic [31:0] i_mem_data,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_addr,
   input  logic        i_stall,
   output logic        o_valid,
   output logic [31:0] o_instruction,
   output logic [31:0] o_pc_plus_4
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

   fq_state_e     r_state;
   fq_state_e     w_state_next;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   w_fetch_pc_next;
   logic [31:0]   w_fetch_pc_plus_4;

   logic          w_push;
   logic          w_pop;
   fq_entry_t     w_wdata;
   fq_entry_t     w_head;
   logic [AW:0]   w_count;

   assign w_fetch_pc_plus_4 = r_fetch_pc + 32'd4;

   // Issue only from IDLE with room left; a redirect suppresses the request
   // so nothing is fetched from the stale stream in the redirect cycle.
   assign o_mem_req  = (r_state == ST_IDLE) && (w_count < C_DEPTH) && !i_redirect;
   assign o_mem_addr = r_fetch_pc;

   assign w_push = !i_redirect && (r_state == ST_WAIT) && i_mem_valid;
   assign w_pop  = !i_redirect && o_valid && !i_stall;

   assign w_wdata.pc_plus_4 = w_fetch_pc_plus_4;
   assign w_wdata.instr     = i_mem_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_fetch_pc <= RESET_PC;
      end else begin
         r_state    <= w_state_next;
         r_fetch_pc <= w_fetch_pc_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_fetch_pc_next = r_fetch_pc;
      if (i_redirect) begin
         w_fetch_pc_next = i_redirect_addr;
         case (r_state)
            // A response arriving alongside the redirect is simply not pushed;
            // otherwise it is still in flight and must be swallowed later.
            ST_WAIT: w_state_next = i_mem_valid ? ST_IDLE : ST_DROP;
            ST_DROP: w_state_next = ST_DROP;
            default: w_state_next = ST_IDLE;
         endcase
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (o_mem_req && i_mem_ready) begin
                  w_state_next = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_mem_valid) begin
                  w_fetch_pc_next = w_fetch_pc_plus_4;
                  w_state_next    = ST_IDLE;
               end
            end
            ST_DROP: begin
               if (i_mem_valid) begin
                  w_state_next = ST_IDLE;
               end
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   fetch_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (i_redirect),
      .i_wdata (w_wdata),
      .o_rdata (w_head),
      .o_count (w_count)
   );

   assign o_valid       = (w_count != '0);
   assign o_instruction = o_valid ? w_head.instr     : NOP_INSTR;
   assign o_pc_plus_4   = o_valid ? w_head.pc_plus_4 : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue (DEPTH=4, RESET_PC=0). Inputs change 1 ns
// after the rising edge; outputs are compared 1 ns after that.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

   logic        clk;
   logic        rst;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_ready;
   logic        i_mem_valid;
   logic [31:0] i_mem_data;
   logic        i_redirect;
   logic [31:0] i_redirect_addr;
   logic        i_stall;
   logic        o_valid;
   logic [31:0] o_instruction;
   logic [31:0] o_pc_plus_4;

   int checks;
   int errors;

   fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .o_mem_req       (o_mem_req),
      .o_mem_addr      (o_mem_addr),
      .i_mem_ready     (i_mem_ready),
      .i_mem_valid     (i_mem_valid),
      .i_mem_data      (i_mem_data),
      .i_redirect      (i_redirect),
      .i_redirect_addr (i_redirect_addr),
      .i_stall         (i_stall),
      .o_valid         (o_valid),
      .o_instruction   (o_instruction),
      .o_pc_plus_4     (o_pc_plus_4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h want=0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%08h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".req"},   {31'b0, o_mem_req}, 32'd1);
      chk({tag, ".addr"},  o_mem_addr,         32'h0);
      chk({tag, ".valid"}, {31'b0, o_valid},   32'd0);
      chk({tag, ".instr"}, o_instruction,      32'h0);
      chk({tag, ".pc4"},   o_pc_plus_4,        32'h0);
   endtask

   // Issue at addr (checked), accept, return data one cycle later (L=1).
   task automatic fetch_one(input string tag, input logic [31:0] addr, input logic [31:0] data);
      i_mem_ready = 1'b1;
      settle();
      chk({tag, ".req"},  {31'b0, o_mem_req}, 32'd1);
      chk({tag, ".addr"}, o_mem_addr,         addr);
      step();
      i_mem_valid = 1'b1;
      i_mem_data  = data;
      settle();
      chk({tag, ".wait_req"}, {31'b0, o_mem_req}, 32'd0);
      step();
      i_mem_valid = 1'b0;
      i_mem_data  = 32'h0;
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      rst             = 1'b1;
      i_mem_ready     = 1'b0;
      i_mem_valid     = 1'b0;
      i_mem_data      = 32'h0;
      i_redirect      = 1'b0;
      i_redirect_addr = 32'h0;
      i_stall         = 1'b1;

      // ---------------- reset state
      step();
      step();
      chk_reset_outputs("rst");
      rst = 1'b0;

      // ---------------- first fetch, L=1
      fetch_one("f0", 32'h0, 32'h2008_0001);
      settle();
      chk("f0.valid", {31'b0, o_valid}, 32'd1);
      chk("f0.instr", o_instruction,    32'h2008_0001);
      chk("f0.pc4",   o_pc_plus_4,      32'h4);

      // ---------------- fill under stall
      fetch_one("f1", 32'h4, 32'h1111_1111);
      fetch_one("f2", 32'h8, 32'h2222_2222);
      fetch_one("f3", 32'hC, 32'h3333_3333);
      settle();
      chk("full.req", {31'b0, o_mem_req}, 32'd0);
      step();
      step();
      chk("full.req_hold", {31'b0, o_mem_req}, 32'd0);
      chk("full.addr",     o_mem_addr,         32'h10);
      chk("full.instr",    o_instruction,      32'h2008_0001);

      // one pop frees a slot
      i_stall = 1'b0;
      step();
      i_stall = 1'b1;
      settle();
      chk("pop.req",   {31'b0, o_mem_req}, 32'd1);
      chk("pop.addr",  o_mem_addr,         32'h10);
      chk("pop.instr", o_instruction,      32'h1111_1111);
      chk("pop.pc4",   o_pc_plus_4,        32'h8);

      // ---------------- ready low for 5 cycles
      i_mem_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         settle();
         chk($sformatf("nrdy%0d.req", k),  {31'b0, o_mem_req}, 32'd1);
         chk($sformatf("nrdy%0d.addr", k), o_mem_addr,         32'h10);
         step();
      end

      // ---------------- redirect + pop + response in the same cycle
      i_mem_ready = 1'b1;
      step();                           // request for 0x10 accepted
      i_mem_ready     = 1'b0;
      i_mem_valid     = 1'b1;
      i_mem_data      = 32'hDEAD_BEEF;
      i_redirect      = 1'b1;
      i_redirect_addr = 32'h80;
      i_stall         = 1'b0;
      settle();
      chk("rpv.req", {31'b0, o_mem_req}, 32'd0);
      step();
      i_mem_valid = 1'b0;
      i_redirect  = 1'b0;
      i_stall     = 1'b1;
      settle();
      chk("rpv.valid", {31'b0, o_valid},   32'd0);
      chk("rpv.req1",  {31'b0, o_mem_req}, 32'd1);
      chk("rpv.addr",  o_mem_addr,         32'h80);
      fetch_one("f80", 32'h80, 32'h5555_5555);
      settle();
      chk("f80.instr", o_instruction, 32'h5555_5555);
      chk("f80.pc4",   o_pc_plus_4,   32'h84);

      // ---------------- reset during WAIT, then a stray response
      i_mem_ready = 1'b1;
      settle();
      chk("rw.addr", o_mem_addr, 32'h84);
      step();                           // request for 0x84 accepted -> WAIT
      i_mem_ready = 1'b0;
      rst = 1'b1;
      settle();
      chk_reset_outputs("rw");
      step();
      rst         = 1'b0;
      i_mem_valid = 1'b1;
      i_mem_data  = 32'hBAD0_0001;
      step();
      i_mem_valid = 1'b0;
      settle();
      chk("stray.valid", {31'b0, o_valid},   32'd0);
      chk("stray.req",   {31'b0, o_mem_req}, 32'd1);
      chk("stray.addr",  o_mem_addr,         32'h0);

      // ---------------- redirect to 0x40 while 0x8 is outstanding
      fetch_one("g0", 32'h0, 32'hA000_0000);
      fetch_one("g1", 32'h4, 32'hA000_0004);
      i_mem_ready = 1'b1;
      settle();
      chk("g2.addr", o_mem_addr, 32'h8);
      step();                           // request for 0x8 accepted
      i_redirect      = 1'b1;
      i_redirect_addr = 32'h40;
      settle();
      step();
      i_redirect = 1'b0;
      settle();
      chk("drop.valid", {31'b0, o_valid},   32'd0);
      chk("drop.req",   {31'b0, o_mem_req}, 32'd0);
      step();
      i_mem_valid = 1'b1;               // late response for 0x8
      i_mem_data  = 32'hA000_0008;
      step();
      i_mem_valid = 1'b0;
      settle();
      chk("drop.valid2", {31'b0, o_valid},   32'd0);
      chk("drop.req2",   {31'b0, o_mem_req}, 32'd1);
      fetch_one("f40", 32'h40, 32'h0040_0013);
      settle();
      chk("f40.valid", {31'b0, o_valid}, 32'd1);
      chk("f40.instr", o_instruction,    32'h0040_0013);
      chk("f40.pc4",   o_pc_plus_4,      32'h44);

      // ---------------- redirect from IDLE to the top word, PC+4 wraps
      i_redirect      = 1'b1;
      i_redirect_addr = 32'hFFFF_FFFC;
      settle();
      chk("wrap.req_masked", {31'b0, o_mem_req}, 32'd0);
      step();
      i_redirect = 1'b0;
      settle();
      chk("wrap.valid", {31'b0, o_valid}, 32'd0);
      fetch_one("fwrap", 32'hFFFF_FFFC, 32'h7777_7777);
      settle();
      chk("wrap.instr", o_instruction, 32'h7777_7777);
      chk("wrap.pc4",   o_pc_plus_4,   32'h0);
      chk("wrap.next",  o_mem_addr,    32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction memory and the IF/ID pipeline register. It issues sequential word fetches, buffers up to DEPTH returned instructions with their PC+4, and presents them to decode. On a taken branch or jump it flushes and restarts from the target, and it holds its output while decode stalls. It replaces the direct PC → instruction-memory → IF/ID path with a decoupled, variable-latency-tolerant front end.

## Interface
- DEPTH, 4: queue entries; power of two, ≥ 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- o_mem_req  out  1  fetch request to instruction memory.
- o_mem_addr  out  32  fetch word address (byte address, [1:0] = 0).
- i_mem_ready  in  1  memory accepts the request this cycle.
- i_mem_valid  in  1  response valid; at most one per accepted request, ≥ 1 cycle after acceptance.
- i_mem_data  in  32  response instruction word.
- i_redirect  in  1  taken branch/jump from the decode hazard unit.
- i_redirect_addr  in  32  target address.
- i_stall  in  1  decode stall; inhibits pop.
- o_valid  out  1  head entry valid.
- o_instruction  out  32  head instruction; 32'h0 (nop) when empty.
- o_pc_plus_4  out  32  head entry's fetch address + 4; 32'h0 when empty.

## Operation
- State: fetch_pc (32b), FIFO of DEPTH × {pc_plus_4, instr}, count (clog2(DEPTH)+1 bits), FSM {IDLE, WAIT, DROP}.
- At most one outstanding request.
- o_mem_req = (state==IDLE) && (count < DEPTH) && !i_redirect; o_mem_addr = fetch_pc.
- IDLE: o_mem_req && i_mem_ready → WAIT. i_mem_valid is ignored in IDLE.
- WAIT: i_mem_valid → push {fetch_pc+4, i_mem_data}, fetch_pc += 4, → IDLE.
- DROP: i_mem_valid → discard the data, → IDLE.
- Pop when o_valid && !i_stall; the head advances at the clock edge.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- A push always fits. Requests are issued only with count < DEPTH, and count cannot grow while WAIT is active.
- Redirect has priority over push, pop and issue:
  - count := 0, pointers := 0, fetch_pc := i_redirect_addr.
  - State IDLE → IDLE.
  - State WAIT: with i_mem_valid the same cycle, the response is discarded → IDLE; without it → DROP.
  - State DROP → DROP; fetch_pc is updated.
- Arithmetic: fetch_pc + 4 wraps modulo 2^32. Pointers wrap modulo DEPTH.

## Timing
- Reset values: state=IDLE, fetch_pc=RESET_PC, count=0, o_valid=0, o_instruction=0, o_pc_plus_4=0, o_mem_req=1 (derived from IDLE with count 0), o_mem_addr=RESET_PC.
- Request accepted in cycle t with response in t+L → entry visible on o_valid in t+L+1 (no bypass).
- With L=1, the next request is issued at t+2. Peak throughput is one instruction per 2 cycles.
- Redirect asserted in cycle t → o_valid=0 in t+1. The request to the target is issued in t+1 if IDLE, or in the cycle after the stale response if DROP.
- o_mem_req, o_valid and head data are combinational from registers (o_mem_req also depends on i_redirect). There are no other input → output paths.
- rst asserted mid-WAIT/DROP: immediate return to the reset values. A later stray i_mem_valid is ignored in IDLE.

## Structure
- Shared package (used with the pipeline's other constants):
  - FSM encoding (IDLE/WAIT/DROP);
  - NOP_INSTR = 32'h0;
  - default RESET_PC.
- One sub-module: fetch_fifo_mem.
  - DEPTH × 64-bit storage with write/read pointers and count.
  - Inputs: push, pop, flush.
  - Top level holds the FSM and fetch_pc.

## Test plan
- Reset release, i_mem_ready=1, L=1:
  - Cycle 0: o_mem_req=1, o_mem_addr=0x0, o_valid=0.
  - After data 0x20080001 returns, the next cycle shows o_valid=1, o_instruction=0x20080001, o_pc_plus_4=0x4.
- i_stall=1, no pops, DEPTH=4:
  - Entries for 0x0, 0x4, 0x8 and 0xC fill the queue; o_mem_req drops to 0 and 0x10 is never requested.
  - One pop re-enables o_mem_req with addr 0x10.
- Redirect to 0x40 while the request for 0x8 is outstanding:
  - o_valid=0 next cycle; the late 0x8 response is discarded.
  - The next o_mem_addr is 0x40, and the first new head has o_pc_plus_4=0x44.
- Redirect, pop and i_mem_valid in the same cycle:
  - Queue empties, response dropped, state IDLE.
  - Next cycle: o_mem_req=1, addr = target.
- i_mem_ready held low for 5 cycles: o_mem_req and o_mem_addr stay stable, with no state change.
- rst pulsed during WAIT:
  - Outputs return to the reset values immediately.
  - A stray i_mem_valid one cycle later produces no entry.
